// File: rtl/ysyx_22041211_lsu_pkg.sv
// ============================================================================
// Module  : ysyx_22041211_lsu_pkg
// Brief   : Shared load/store codes, LSU state encodings and size helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22041211_lsu_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  localparam logic [1:0] STORE_SB = 2'b01;
  localparam logic [1:0] STORE_SH = 2'b10;
  localparam logic [1:0] STORE_SW = 2'b11;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_RESP = 2'd2;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Unrecognised store codes are treated as full-word accesses.
  function automatic acc_size_e f_store_size(input logic [1:0] st);
    case (st)
      STORE_SB: return SZ_BYTE;
      STORE_SH: return SZ_HALF;
      default:  return SZ_WORD;
    endcase
  endfunction

  function automatic acc_size_e f_load_size(input logic [2:0] lt);
    case (lt)
      LOAD_LB, LOAD_LBU: return SZ_BYTE;
      LOAD_LH, LOAD_LHU: return SZ_HALF;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic logic f_misaligned(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22041211_lsu_align.sv
// ============================================================================
// Module  : ysyx_22041211_lsu_align
// Brief   : Store lane replication/strobes and load lane extraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                i_is_store,
  input  logic [1:0]          i_st_off,
  input  logic [1:0]          i_st_type,
  input  logic [DATA_LEN-1:0] i_st_data,
  output logic [DATA_LEN-1:0] o_st_data,
  output logic [3:0]          o_st_strb,
  input  logic [1:0]          i_ld_off,
  input  logic [2:0]          i_ld_type,
  input  logic [DATA_LEN-1:0] i_ld_rdata,
  output logic [DATA_LEN-1:0] o_ld_data
);

  logic [DATA_LEN-1:0] w_shifted;

  // Sub-word stores replicate the value so every candidate lane carries it.
  always_comb begin
    o_st_data = i_st_data;
    o_st_strb = WSTRB_NONE;
    if (i_is_store) begin
      case (f_store_size(i_st_type))
        SZ_BYTE: begin
          o_st_data = {(DATA_LEN/8){i_st_data[7:0]}};
          o_st_strb = WSTRB_B << i_st_off;
        end
        SZ_HALF: begin
          o_st_data = {(DATA_LEN/16){i_st_data[15:0]}};
          o_st_strb = WSTRB_H << {i_st_off[1], 1'b0};
        end
        default: o_st_strb = WSTRB_W;
      endcase
    end
  end

  assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = '0;
    case (i_ld_type)
      LOAD_NONE:         o_ld_data = '0;
      LOAD_LB, LOAD_LBU: o_ld_data = {{(DATA_LEN-8){1'b0}}, w_shifted[7:0]};
      LOAD_LH, LOAD_LHU: o_ld_data = {{(DATA_LEN-16){1'b0}}, w_shifted[15:0]};
      default:           o_ld_data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22041211_lsu.sv
// ============================================================================
// Module  : ysyx_22041211_lsu
// Brief   : Load/store unit: EX handshake, req/ack data bus, registered WB result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                mem_wen_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] alu_result_o,
  output logic [DATA_LEN-1:0] mem_rdata_o,
  output logic [2:0]          load_type_o,
  output logic                err_o
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [1:0]          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_req;
  logic                r_we;
  logic [DATA_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_valid;
  logic                r_wd;
  logic [4:0]          r_wreg;
  logic [DATA_LEN-1:0] r_alu;
  logic [DATA_LEN-1:0] r_rdata;
  logic [2:0]          r_ltype;
  logic                r_err;

  logic                w_is_mem;
  acc_size_e           w_size;
  logic                w_mis;
  logic                w_go_bus;
  logic                w_ready;
  logic                w_accept;
  logic [DATA_LEN-1:0] w_st_data;
  logic [3:0]          w_st_strb;
  logic [DATA_LEN-1:0] w_ld_data;

  assign w_is_mem = mem_wen_i || (load_type_i != LOAD_NONE);
  assign w_size   = mem_wen_i ? f_store_size(store_type_i) : f_load_size(load_type_i);
  assign w_mis    = w_is_mem && f_misaligned(w_size, alu_result_i[1:0]);
  assign w_go_bus = w_is_mem && !w_mis;
  assign w_ready  = (r_state == LSU_IDLE) || ((r_state == LSU_RESP) && ready_i);
  assign w_accept = valid_i && w_ready;

  ysyx_22041211_lsu_align #(
    .DATA_LEN (DATA_LEN)
  ) u_align (
    .i_is_store (mem_wen_i),
    .i_st_off   (alu_result_i[1:0]),
    .i_st_type  (store_type_i),
    .i_st_data  (mem_wdata_i),
    .o_st_data  (w_st_data),
    .o_st_strb  (w_st_strb),
    .i_ld_off   (r_alu[1:0]),
    .i_ld_type  (r_ltype),
    .i_ld_rdata (mem_rdata_i),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= LSU_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_valid <= 1'b0;
      r_wd    <= 1'b0;
      r_wreg  <= '0;
      r_alu   <= '0;
      r_rdata <= '0;
      r_ltype <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      // A store alongside a load code is treated as a plain store.
      r_state <= w_go_bus ? LSU_REQ : LSU_RESP;
      r_cnt   <= '0;
      r_req   <= w_go_bus;
      r_we    <= mem_wen_i;
      r_addr  <= {alu_result_i[DATA_LEN-1:2], 2'b00};
      r_wdata <= w_st_data;
      r_wstrb <= w_st_strb;
      r_valid <= !w_go_bus;
      r_wd    <= wd_i && !w_mis;
      r_wreg  <= wreg_i;
      r_alu   <= alu_result_i;
      r_rdata <= '0;
      r_ltype <= mem_wen_i ? LOAD_NONE : load_type_i;
      r_err   <= w_mis;
    end else begin
      case (r_state)
        LSU_REQ: begin
          if (mem_ack_i) begin
            r_state <= LSU_RESP;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_rdata <= w_ld_data;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= LSU_RESP;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_wd    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        LSU_RESP: begin
          if (ready_i) begin
            r_state <= LSU_IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        LSU_IDLE: ;
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign ready_o      = w_ready;
  assign mem_req_o    = r_req;
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_wstrb_o  = r_wstrb;
  assign valid_o      = r_valid;
  assign wd_o         = r_wd;
  assign wreg_o       = r_wreg;
  assign alu_result_o = r_alu;
  assign mem_rdata_o  = r_rdata;
  assign load_type_o  = r_ltype;
  assign err_o        = r_err;

endmodule

`default_nettype wire
